// File: rtl/alu_pkg.sv
// Shared types and constants for the 5-bit signed ALU and its command issuer.
package alu_pkg;

  localparam int OPND_W    = 5;
  localparam int RES_W     = 6;
  localparam int DEF_TAG_W = 4;

  typedef enum logic [1:0] {
    MODE_NONE = 2'b00,
    MODE_A    = 2'b01,
    MODE_B    = 2'b10,
    MODE_AB   = 2'b11
  } mode_e;

  localparam logic [2:0] AOP_0 = 3'b000;
  localparam logic [2:0] AOP_1 = 3'b001;
  localparam logic [2:0] AOP_2 = 3'b010;
  localparam logic [2:0] AOP_3 = 3'b011;
  localparam logic [2:0] AOP_4 = 3'b100;
  localparam logic [2:0] AOP_5 = 3'b101;
  localparam logic [2:0] AOP_6 = 3'b110;

  localparam logic [1:0] BOP_0 = 2'b00;
  localparam logic [1:0] BOP_1 = 2'b01;
  localparam logic [1:0] BOP_2 = 2'b10;
  localparam logic [1:0] BOP_3 = 2'b11;

  typedef struct packed {
    logic signed [RES_W-1:0] data;
    logic [DEF_TAG_W-1:0]    tag;
    logic                    err;
  } res_t;

  // Opcode 111 does not exist on the A side, and B-only mode has no opcode 11.
  function automatic logic cmd_illegal(input logic [1:0] mode, input logic [2:0] op);
    logic bad;
    bad = 1'b0;
    case (mode_e'(mode))
      MODE_NONE: bad = 1'b1;
      MODE_A:    bad = (op == 3'b111);
      MODE_B:    bad = (op[1:0] == 2'b11);
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Small synchronous FIFO holding returned ALU results, generic over the payload type.
module alu_res_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = alu_pkg::res_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  T                           wdata,
  input  logic                       pop,
  output T                           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset; readers only look at it while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issues commands to the registered ALU, captures its result two cycles later and
// returns tagged results in order through a credit-protected FIFO.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_mode,
  input  logic [2:0]               cmd_op,
  input  logic signed [OPND_W-1:0] cmd_a,
  input  logic signed [OPND_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]         cmd_tag,
  output logic                     ALU_en,
  output logic                     a_en,
  output logic                     b_en,
  output logic [2:0]               a_op,
  output logic [1:0]               b_op,
  output logic signed [OPND_W-1:0] A,
  output logic signed [OPND_W-1:0] B,
  input  logic signed [RES_W-1:0]  C,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [RES_W-1:0]  res_data,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     res_err,
  output logic                     busy
);

  localparam int CW = $clog2(RES_DEPTH + 1);

  typedef struct packed {
    logic signed [RES_W-1:0] data;
    logic [TAG_W-1:0]        tag;
    logic                    err;
  } entry_t;

  logic             accept;
  logic             illegal;
  logic             s1_valid, s1_err, s2_valid, s2_err;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  entry_t           push_entry, head;

  // Credits count everything already committed, so the FIFO can never overflow.
  assign cmd_ready = (32'(fifo_count) + 32'(s1_valid) + 32'(s2_valid)) < 32'(RES_DEPTH);
  assign accept    = cmd_valid && cmd_ready;
  assign illegal   = cmd_illegal(cmd_mode, cmd_op);
  assign ALU_en    = s1_valid && !s1_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_tag   <= '0;
      a_en     <= 1'b0;
      b_en     <= 1'b0;
      a_op     <= '0;
      b_op     <= '0;
      A        <= '0;
      B        <= '0;
      s2_valid <= 1'b0;
      s2_err   <= 1'b0;
      s2_tag   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        a_en   <= cmd_mode[0];
        b_en   <= cmd_mode[1];
        a_op   <= cmd_op;
        b_op   <= cmd_op[1:0];
        A      <= cmd_a;
        B      <= cmd_b;
        s1_tag <= cmd_tag;
        s1_err <= illegal;
      end
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      s2_err   <= s1_err;
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.data = s2_err ? '0 : C;
    push_entry.tag  = s2_tag;
    push_entry.err  = s2_err;
  end

  alu_res_fifo #(
    .DEPTH (RES_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s2_valid && !fifo_full),
    .wdata (push_entry),
    .pop   (res_ready),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs read zero while empty so stale storage never shows after reset.
  assign res_valid = !fifo_empty;
  assign res_data  = res_valid ? head.data : '0;
  assign res_tag   = res_valid ? head.tag  : '0;
  assign res_err   = res_valid ? head.err  : 1'b0;
  assign busy      = s1_valid || s2_valid || res_valid;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer with a behavioural registered ALU and an
// expected-result queue filled with hand-computed values.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int RES_DEPTH = 4;
  localparam int TAG_W     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_mode = '0;
  logic [2:0]        cmd_op = '0;
  logic signed [4:0] cmd_a = '0;
  logic signed [4:0] cmd_b = '0;
  logic [3:0]        cmd_tag = '0;
  logic              ALU_en, a_en, b_en;
  logic [2:0]        a_op;
  logic [1:0]        b_op;
  logic signed [4:0] A, B;
  logic signed [5:0] C = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic signed [5:0] res_data;
  logic [3:0]        res_tag;
  logic              res_err;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int alu_en_cnt = 0;
  int last_accept = 0;
  logic [10:0] exp_q[$];

  alu_cmd_issuer #(.RES_DEPTH(RES_DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .ALU_en(ALU_en), .a_en(a_en), .b_en(b_en), .a_op(a_op), .b_op(b_op),
    .A(A), .B(B), .C(C),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: B-side opcode wins when b_en is set, otherwise the A-side opcode.
  function automatic logic signed [5:0] alu_model(input logic ae, input logic be,
      input logic [2:0] aop, input logic [1:0] bop,
      input logic signed [4:0] xa, input logic signed [4:0] xb);
    logic signed [5:0] sa, sb, r;
    sa = {xa[4], xa};
    sb = {xb[4], xb};
    r  = '0;
    if (be) begin
      case (bop)
        2'b00:   r = sb;
        2'b01:   r = -sb;
        2'b10:   r = sa + sb;
        default: r = sb + 6'sd2;
      endcase
    end else if (ae) begin
      case (aop)
        3'b000:  r = sa + sb;
        3'b001:  r = sa - sb;
        3'b010:  r = sa & sb;
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ALU_en) begin
      C          <= alu_model(a_en, b_en, a_op, b_op, A, B);
      alu_en_cnt <= alu_en_cnt + 1;
    end
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Every handshake on the result side is matched against the next expected entry.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) check_output("spurious_result", 1, 0);
      else begin
        check_output("result", 32'({res_err, res_tag, res_data}), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic apply_stimulus(input logic [1:0] mode, input logic [2:0] op,
      input int xa, input int xb, input int tag, input int exp_data, input logic exp_err);
    int waited;
    waited    = 0;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_op    = op;
    cmd_a     = 5'(xa);
    cmd_b     = 5'(xb);
    cmd_tag   = 4'(tag);
    @(negedge clk);
    while (!cmd_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!cmd_ready) begin
      check_output("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back({exp_err, 4'(tag), 6'(exp_data)});
    @(posedge clk);
    #1;
    last_accept = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("drain", 32'(exp_q.size()) + 32'(busy), 0);
  endtask

  task automatic check_reset_values(input string name);
    check_output(name, 32'({ALU_en, a_en, b_en, a_op, b_op, A, B,
                            res_valid, res_data, res_tag, res_err, busy}), 0);
  endtask

  initial begin
    int first_accept;
    int cnt0;
    logic stall_bad;
    logic stale;

    repeat (3) @(negedge clk);
    check_reset_values("reset_outputs");
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("ready_after_reset", 32'(cmd_ready), 1);

    // Latency of a single A-only add, result held with res_ready low.
    @(posedge clk);
    #1;
    apply_stimulus(2'b01, 3'b000, 5, -3, 1, 2, 1'b0);
    @(negedge clk);
    check_output("alu_en_issue", 32'(ALU_en), 1);
    check_output("res_valid_n1", 32'(res_valid), 0);
    @(negedge clk);
    check_output("res_valid_n2", 32'(res_valid), 0);
    @(negedge clk);
    check_output("res_valid_n3", 32'(res_valid), 1);
    check_output("res_data_add", 32'(res_data), 32'(2));
    @(posedge clk);
    #1 res_ready = 1'b1;
    wait_drain();

    // Sign-extension cases.
    @(posedge clk);
    #1;
    apply_stimulus(2'b01, 3'b000, 15, 15, 2, 30, 1'b0);
    apply_stimulus(2'b01, 3'b001, -16, 15, 3, -31, 1'b0);
    apply_stimulus(2'b11, 3'b011, 0, -16, 4, -14, 1'b0);
    @(negedge clk);
    check_output("ports_ab", 32'({ALU_en, a_en, b_en, b_op}), 32'(5'b11111));
    check_output("port_B", 32'(B), 32'(-16));
    wait_drain();

    // Back-to-back issue, tags 0..7.
    @(posedge clk);
    #1;
    first_accept = 0;
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(2'b01, 3'b000, i, 1, i, i + 1, 1'b0);
      if (i == 0) first_accept = last_accept;
    end
    check_output("b2b_no_bubbles", 32'(last_accept - first_accept), 7);
    wait_drain();

    // Back-pressure: four accepted, fifth held off until the first pop.
    @(posedge clk);
    #1 res_ready = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(2'b01, 3'b000, i, 1, i, i + 1, 1'b0);
    @(negedge clk);
    check_output("bp_ready_low", 32'(cmd_ready), 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_mode  = 2'b01;
    cmd_op    = 3'b000;
    cmd_tag   = 4'd4;
    stall_bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cmd_ready || !res_valid || res_tag != 4'd0) stall_bad = 1'b1;
    end
    check_output("bp_stall_stable", 32'(stall_bad), 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check_output("bp_ready_before_pop", 32'(cmd_ready), 0);
    @(negedge clk);
    check_output("bp_ready_after_pop", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    apply_stimulus(2'b01, 3'b000, 4, 1, 4, 5, 1'b0);
    apply_stimulus(2'b01, 3'b000, 5, 1, 5, 6, 1'b0);
    wait_drain();

    // Illegal commands must not enable the ALU nor disturb C.
    @(posedge clk);
    #1;
    apply_stimulus(2'b01, 3'b000, 3, 4, 8, 7, 1'b0);
    wait_drain();
    cnt0 = alu_en_cnt;
    check_output("c_legal", 32'(C), 32'(7));
    @(posedge clk);
    #1;
    apply_stimulus(2'b00, 3'b000, 3, 3, 9, 0, 1'b1);
    apply_stimulus(2'b01, 3'b111, 3, 3, 10, 0, 1'b1);
    apply_stimulus(2'b10, 3'b011, 3, 3, 11, 0, 1'b1);
    wait_drain();
    check_output("illegal_alu_en", 32'(alu_en_cnt - cnt0), 0);
    check_output("c_unchanged", 32'(C), 32'(7));
    @(posedge clk);
    #1;
    apply_stimulus(2'b10, 3'b101, 0, 5, 12, -5, 1'b0);
    wait_drain();

    // Reset with three commands in flight.
    @(posedge clk);
    #1 res_ready = 1'b0;
    apply_stimulus(2'b01, 3'b000, 1, 1, 1, 2, 1'b0);
    apply_stimulus(2'b01, 3'b000, 2, 1, 2, 3, 1'b0);
    apply_stimulus(2'b01, 3'b000, 3, 1, 3, 4, 1'b0);
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_values("midop_reset_outputs");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    res_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid || busy) stale = 1'b1;
    end
    check_output("no_stale_result", 32'(stale), 0);
    check_output("ready_after_midop_reset", 32'(cmd_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

- Command-side initiator for the 5-bit signed ALU.
- Accepts operation commands over a valid/ready stream, drives the ALU control and operand ports, and captures the registered ALU result at the correct cycle.
- Returns results in order, tagged, over a second valid/ready stream backed by a small result FIFO with credit-based flow control.
- Sits between the stimulus/command source and the ALU, so no ALU result is ever lost under back-pressure.

## Interface

Parameters:
- RES_DEPTH, default 4: result FIFO depth and maximum number of in-flight plus buffered commands. Must be 2 or more.
- TAG_W, default 4: command/result tag width.

Ports:
- clk, input, 1: single clock; all flops rise-edge.
- rst_n, input, 1: asynchronous, active-low reset. The polarity and synchronicity are fixed.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: command accepted when both cmd_valid and cmd_ready are high on a rising edge.
- cmd_mode, input, 2: operation mode. 00 is none (illegal), 01 is A-only, 10 is B-only, 11 is both.
- cmd_op, input, 3: opcode. A-only uses all 3 bits; the B modes use bits [1:0], and bit 2 is ignored.
- cmd_a, input, 5: signed operand A.
- cmd_b, input, 5: signed operand B.
- cmd_tag, input, TAG_W: opaque tag, returned with the result.
- ALU_en, output, 1: ALU enable.
- a_en, output, 1: ALU A-enable.
- b_en, output, 1: ALU B-enable.
- a_op, output, 3: ALU A opcode.
- b_op, output, 2: ALU B opcode.
- A, output, 5: signed ALU operand A.
- B, output, 5: signed ALU operand B.
- C, input, 6: signed ALU result, registered inside the ALU.
- res_valid, output, 1: result present at the FIFO head.
- res_ready, input, 1: result consumed when both res_valid and res_ready are high on a rising edge.
- res_data, output, 6: signed result.
- res_tag, output, TAG_W: tag of the command that produced the result.
- res_err, output, 1: set when the command was illegal; res_data is then 0.
- busy, output, 1: any command is in stage 1, in stage 2, or in the FIFO.

## Operation

**Issue stage (S1)**
- On accept, register the ALU drive:
  - a_en = mode[0], b_en = mode[1].
  - a_op = cmd_op, b_op = cmd_op[1:0].
  - A = cmd_a, B = cmd_b.
- s1_valid, s1_tag and s1_err are registered alongside.

**Error classification, decided at accept**
- cmd_mode 00.
- cmd_mode 01 with cmd_op 111.
- cmd_mode 10 with cmd_op[1:0] 11.
- For an erroring command, ALU_en stays 0, so C is not disturbed.

**ALU enable**
- ALU_en = s1_valid and not s1_err.
- When S1 is empty, ALU_en = 0 and the operand/opcode outputs hold their last value.

**Capture stage (S2)**
- S1 advances unconditionally into s2_valid, s2_tag and s2_err.
- While s2_valid is set, the FIFO is written with:
  - res_data = C when s2_err = 0, otherwise 0;
  - the tag;
  - the err flag.

**Credits and ordering**
- cmd_ready = (fifo_count + s1_valid + s2_valid) < RES_DEPTH.
- Because of this credit rule, a FIFO write never meets a full FIFO.
- Results are delivered strictly in acceptance order.
- A FIFO push and pop in the same cycle are both honoured, and the count is unchanged.
- res_valid = FIFO not empty. res_data, res_tag and res_err show the FIFO head.
- Holding rule: while res_valid is high and res_ready is low, the head is stable.

**Reset**
- An assertion at any time, including mid-operation, drops S1, S2 and the FIFO contents. No partial results are emitted.

## Timing

**Reset values**
- ALU_en, a_en, b_en = 0.
- a_op = 0, b_op = 0, A = 0, B = 0.
- res_valid = 0, res_data = 0, res_tag = 0, res_err = 0, busy = 0.
- cmd_ready = 1 from the first cycle after deassertion.

**Latency**
- Command accepted at edge N.
- ALU ports valid and ALU samples at edge N+1.
- C valid after edge N+1; the FIFO write happens at edge N+2.
- res_valid is high after edge N+2. Minimum accept-to-result latency is 2 cycles.

**Throughput**
- One command per cycle sustained when res_ready is held at 1.

**Back-pressure**
- With res_ready = 0, exactly RES_DEPTH commands are accepted.
- After the RES_DEPTH-th accept, cmd_ready goes low.
- cmd_ready rises in the cycle after the first pop.

**Combinational paths**
- cmd_ready depends only on registered state. There is no combinational path from cmd_valid or res_ready.

## Structure

**Shared package alu_pkg**
- mode_e: MODE_NONE, MODE_A, MODE_B, MODE_AB.
- A-op constants 000–110 and B-op constants 00–11.
- Operand width constant 5 and result width constant 6.
- res_t struct: data, tag, err.

**Sub-module alu_res_fifo**
- Synchronous FIFO parameterised by depth and payload type.
- Provides count, full and empty outputs.
- Binary pointers with wrap-around at RES_DEPTH.

## Test plan

- **A-only add.** Mode 01, op 000, A=5, B=-3, tag 1. Require res_data = 2, tag 1, err 0, two cycles after accept.
- **Sign-extension, both modes.**
  - Mode 01, op 000, A=15, B=15 -> 30.
  - Mode 01, op 001, A=-16, B=15 -> -31.
  - Mode 11, op 11, B=-16 -> -14.
- **Back-to-back issue.** Send 8 commands on consecutive cycles, tags 0–7, with res_ready = 1. Require zero bubbles and results in tag order 0–7.
- **Back-pressure.** Hold res_ready = 0 and offer 6 commands. Require:
  - exactly 4 accepted, then cmd_ready = 0;
  - after res_ready is released, tags 0–3 drain, then the remaining 2 are accepted and returned.
- **Illegal commands.** Send:
  - mode 00;
  - mode 01 with op 111;
  - mode 10 with op 011.

  Require err = 1 and data 0 for each, ALU_en never asserted for them, and C unchanged for a following legal command.
- **Reset mid-operation.** Assert rst_n low with 3 commands in flight. Require all outputs at their reset values, busy = 0 and no stale result after release.
